// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage sequencer for a multi-cycle instruction memory: owns the PC, issues one read at a
// time, hands instructions to decode under valid/stall, and applies redirects and HALT.
module imem_fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  input  logic        mem_err,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        stall,
  output logic [15:0] instr_out,
  output logic [15:0] pc_add,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StValid,
    StHalted
  } state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_pc, w_pc_d;
  logic [15:0] r_target, w_target_d;
  logic [15:0] r_instr, w_instr_d;
  logic [15:0] r_pc_add, w_pc_add_d;
  logic        r_kill, w_kill_d;
  logic        r_halt_pend, w_halt_pend_d;
  logic        r_err, w_err_d;
  logic [16:0] w_pc_inc;

  // Bit 16 is the wrap indicator used to flag err.
  assign w_pc_inc = {1'b0, r_pc} + 17'd2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_target    <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_pc_add    <= 16'h0000;
      r_kill      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_target    <= w_target_d;
      r_instr     <= w_instr_d;
      r_pc_add    <= w_pc_add_d;
      r_kill      <= w_kill_d;
      r_halt_pend <= w_halt_pend_d;
      r_err       <= w_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_target_d    = r_target;
    w_instr_d     = r_instr;
    w_pc_add_d    = r_pc_add;
    w_kill_d      = r_kill;
    w_halt_pend_d = r_halt_pend;
    w_err_d       = r_err;

    unique case (r_state)
      StIdle: begin
        if (redirect) begin
          w_pc_d    = redirect_pc;
          w_state_d = StReq;
        end else if (halt) begin
          w_state_d = StHalted;
        end else begin
          w_state_d = StReq;
        end
      end

      StReq: begin
        if (redirect) begin
          w_pc_d = redirect_pc;
          // The old address was accepted this cycle: treat it as in flight and kill it.
          if (!mem_stall) begin
            w_kill_d   = 1'b1;
            w_target_d = redirect_pc;
            w_state_d  = StWait;
          end
        end else if (halt) begin
          w_state_d = StHalted;
        end else if (!mem_stall) begin
          w_state_d = StWait;
        end
      end

      StWait: begin
        if (mem_done && mem_err) begin
          w_err_d = 1'b1;
        end
        if (redirect) begin
          w_halt_pend_d = 1'b0;
          if (mem_done) begin
            w_pc_d    = redirect_pc;
            w_kill_d  = 1'b0;
            w_state_d = StReq;
          end else begin
            w_kill_d   = 1'b1;
            w_target_d = redirect_pc;
          end
        end else if (mem_done) begin
          w_kill_d      = 1'b0;
          w_halt_pend_d = 1'b0;
          if (r_halt_pend || halt) begin
            w_state_d = StHalted;
          end else if (r_kill) begin
            w_pc_d    = r_target;
            w_state_d = StReq;
          end else begin
            w_instr_d  = mem_data;
            w_pc_add_d = w_pc_inc[15:0];
            w_state_d  = StValid;
          end
        end else if (halt) begin
          w_halt_pend_d = 1'b1;
        end
      end

      StValid: begin
        if (redirect) begin
          w_pc_d    = redirect_pc;
          w_state_d = StReq;
        end else if (halt) begin
          w_state_d = StHalted;
        end else if (!stall) begin
          w_pc_d    = w_pc_inc[15:0];
          w_state_d = StReq;
          if (w_pc_inc[16]) begin
            w_err_d = 1'b1;
          end
        end
      end

      StHalted: begin
        w_state_d = StHalted;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign mem_addr    = r_pc;
  assign mem_rd      = (r_state == StReq);
  assign instr_valid = (r_state == StValid);
  assign instr_out   = instr_valid ? r_instr : NOP_INSTR;
  assign pc_add      = r_pc_add;
  assign halted      = (r_state == StHalted);
  assign err         = r_err;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios, then randomized traffic checked by a
// queue-based scoreboard against an architectural PC model.
module tb_imem_fetch_ctrl;

  localparam logic [15:0] ResetPc = 16'h0000;
  localparam logic [15:0] Nop     = 16'h0800;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_data;
  logic        mem_err;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        stall;
  logic [15:0] instr_out;
  logic [15:0] pc_add;
  logic        instr_valid;
  logic        halted;
  logic        err;

  imem_fetch_ctrl #(
    .RESET_PC (ResetPc),
    .NOP_INSTR(Nop)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_stall  (mem_stall),
    .mem_done   (mem_done),
    .mem_data   (mem_data),
    .mem_err    (mem_err),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .stall      (stall),
    .instr_out  (instr_out),
    .pc_add     (pc_add),
    .instr_valid(instr_valid),
    .halted     (halted),
    .err        (err)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc_add;
  } exp_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_deliv = 0;
  bit          mem_rand = 0;
  int          fix_lat = 0;
  bit          stall_force = 0;
  bit          err_force = 0;
  bit          sb_on = 0;
  exp_t        exp_q[$];
  logic [15:0] m_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Memory contents: a simple function of the word address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA001 + (a >> 1);
  endfunction

  function automatic exp_t mk(input logic [15:0] a);
    exp_t e;
    e.addr   = a;
    e.instr  = mem_word(a);
    e.pc_add = a + 16'd2;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!instr_valid && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic wait_rd(input int max, output int n, output bit saw_valid);
    n = 0;
    saw_valid = 0;
    while (!mem_rd && n < max) begin
      step();
      n++;
      saw_valid |= instr_valid;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instr_out"}, instr_out, Nop);
    chk({tag, "_pc_add"}, pc_add, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, ResetPc);
  endtask

  // Memory responder: one read at a time, fixed or random latency and request stalls.
  initial begin : mem_model
    bit          acc;
    logic [15:0] acc_addr;
    logic [15:0] rd_addr;
    bit          busy;
    int          cnt;
    busy      = 0;
    cnt       = 0;
    rd_addr   = '0;
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    mem_data  = '0;
    mem_err   = 1'b0;
    forever begin
      @(negedge clk);
      acc      = mem_rd && !mem_stall;
      acc_addr = mem_addr;
      @(posedge clk);
      #1;
      mem_done = 1'b0;
      mem_err  = 1'b0;
      if (!rst) begin
        busy      = 0;
        mem_stall = 1'b0;
      end else begin
        if (acc) begin
          busy    = 1;
          rd_addr = acc_addr;
          cnt     = mem_rand ? int'($urandom_range(0, 3)) : fix_lat;
        end
        if (busy) begin
          if (cnt == 0) begin
            mem_done = 1'b1;
            mem_data = mem_word(rd_addr);
            mem_err  = err_force;
            busy     = 0;
          end else begin
            cnt--;
          end
        end
        if (mem_rand) mem_stall = mem_rd && ($urandom_range(0, 3) == 0);
        else mem_stall = mem_rd && stall_force;
      end
    end
  end

  // Scoreboard monitor: the front entry is the instruction decode must see next.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb_on && rst) begin
        if (exp_q.size() == 0) begin
          chk("sb_queue_nonempty", 0, 1);
        end else begin
          if (instr_valid) begin
            chk("sb_instr", instr_out, exp_q[0].instr);
            chk("sb_pc_add", pc_add, exp_q[0].pc_add);
          end else begin
            chk("sb_nop", instr_out, Nop);
          end
          if (mem_rd) chk("sb_mem_addr", mem_addr, exp_q[0].addr);
          if (redirect || (instr_valid && !stall)) begin
            if (!redirect) n_deliv++;
            exp_q.delete(0);
          end
        end
      end
    end
  end

  initial begin : main
    int n;
    bit saw;
    bit any_act;
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    stall       = 1'b0;
    repeat (2) step();
    chk_reset("rst0");

    // Back-to-back fetches with zero-wait memory.
    rst = 1'b1;
    step();
    chk("t1_mem_rd0", mem_rd, 1);
    chk("t1_mem_addr0", mem_addr, 16'h0000);
    wait_valid(10, n);
    chk("t1_latency0", n, 2);
    chk("t1_instr0", instr_out, 16'hA001);
    chk("t1_pc_add0", pc_add, 16'h0002);
    step();
    chk("t1_valid_pulse", instr_valid, 0);
    chk("t1_mem_addr1", mem_addr, 16'h0002);
    wait_valid(10, n);
    chk("t1_cycles_per_instr", n + 1, 3);
    chk("t1_instr1", instr_out, 16'hA002);
    chk("t1_pc_add1", pc_add, 16'h0004);

    // Decode stall holds the instruction.
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_valid", instr_valid, 1);
      chk("t3_hold_instr", instr_out, 16'hA002);
      chk("t3_hold_pc_add", pc_add, 16'h0004);
      chk("t3_hold_no_rd", mem_rd, 0);
    end

    // Memory stalls the request for 3 cycles, then 4 wait cycles.
    stall       = 1'b0;
    stall_force = 1'b1;
    fix_lat     = 4;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) stall_force = 1'b0;
      step();
      chk("t2_rd_held", mem_rd, 1);
      chk("t2_rd_addr", mem_addr, 16'h0004);
    end
    step();
    chk("t2_rd_released", mem_rd, 0);
    wait_valid(20, n);
    chk("t2_wait_cycles", n, 5);
    chk("t2_instr", instr_out, mem_word(16'h0004));
    chk("t2_pc_add", pc_add, 16'h0006);
    step();
    chk("t2_single_valid", instr_valid, 0);

    // Redirect on an accepted request, then redirect while a read is in flight.
    fix_lat     = 3;
    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    wait_rd(20, n, saw);
    chk("t4_no_valid_a", saw, 0);
    chk("t4_rd_a", mem_rd, 1);
    chk("t4_addr_a", mem_addr, 16'h0010);
    step();
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    wait_rd(20, n, saw);
    chk("t4_killed_no_valid", saw, 0);
    chk("t4_addr_b", mem_addr, 16'h0100);
    wait_valid(20, n);
    chk("t4_valid", instr_valid, 1);
    chk("t4_instr", instr_out, mem_word(16'h0100));
    chk("t4_pc_add", pc_add, 16'h0102);

    // halt together with redirect is ignored; a later halt in WAIT drains the read.
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    halt     = 1'b0;
    redirect = 1'b0;
    chk("t5_not_halted", halted, 0);
    chk("t5_rd", mem_rd, 1);
    chk("t5_addr", mem_addr, 16'h0040);
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    n   = 0;
    saw = 0;
    while (!halted && n < 20) begin
      saw |= instr_valid;
      step();
      n++;
    end
    chk("t5_halted", halted, 1);
    chk("t5_drained_no_valid", saw, 0);
    any_act = 0;
    for (int k = 0; k < 6; k++) begin
      redirect = (k < 2);
      step();
      any_act |= mem_rd | instr_valid;
    end
    redirect = 1'b0;
    chk("t5_quiet_after_halt", any_act, 0);
    chk("t5_halt_sticky", halted, 1);

    // Reset, then wrap the PC from 0xFFFE.
    rst = 1'b0;
    step();
    chk_reset("rst1");
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("t6_addr_fffe", mem_addr, 16'hFFFE);
    wait_valid(20, n);
    chk("t6_instr_fffe", instr_out, mem_word(16'hFFFE));
    chk("t6_pc_add_wrap", pc_add, 16'h0000);
    step();
    chk("t6_err_wrap", err, 1);
    chk("t6_pc_wrapped", mem_addr, 16'h0000);
    wait_valid(20, n);
    chk("t6_pc_add_after", pc_add, 16'h0002);
    step();
    chk("t6_err_sticky", err, 1);

    // Asynchronous reset in the middle of a read.
    step();
    #1;
    rst = 1'b0;
    #1;
    chk_reset("rst_async");
    step();
    rst       = 1'b1;
    err_force = 1'b1;
    wait_valid(20, n);
    err_force = 1'b0;
    chk("t7_mem_err", err, 1);
    chk("t7_instr", instr_out, mem_word(16'h0000));
    step();
    wait_valid(20, n);
    chk("t7_fetch_continues", pc_add, 16'h0004);

    // Randomized traffic against the scoreboard.
    rst = 1'b0;
    step();
    mem_rand = 1;
    exp_q.delete();
    m_pc = ResetPc;
    exp_q.push_back(mk(m_pc));
    sb_on = 1;
    rst   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 16'($urandom_range(0, 16'h3FFF));
      if (redirect) begin
        m_pc = redirect_pc;
        exp_q.push_back(mk(m_pc));
      end else if (instr_valid && !stall) begin
        m_pc = m_pc + 16'd2;
        exp_q.push_back(mk(m_pc));
      end
      step();
    end
    sb_on    = 0;
    redirect = 1'b0;
    stall    = 1'b0;
    chk("sb_deliveries", n_deliv >= 50, 1);
    chk("sb_queue_depth", exp_q.size(), 1);
    chk("sb_err_clear", err, 0);
    chk("sb_not_halted", halted, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
